// File: rtl/ray_tri_sequencer.sv
// Per-ray triangle sequencer: fetches a triangle list one word at a time, feeds the
// combinational intersection unit and reports the lowest-index valid hit.
module ray_tri_sequencer #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned CNT_W      = 16,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ray_valid,
  output logic                     o_ray_ready,
  input  logic [0:1][0:2][31:0]    i_ray,
  input  logic [ADDR_W-1:0]        i_base_addr,
  input  logic [CNT_W-1:0]         i_num_tris,
  output logic                     o_mem_rd,
  output logic [ADDR_W-1:0]        o_mem_addr,
  input  logic                     i_mem_waitrequest,
  input  logic [0:2][0:2][31:0]    i_mem_rddata,
  input  logic                     i_mem_rddatavalid,
  output logic [0:2][0:2][31:0]    o_isect_tri,
  output logic [0:1][0:2][31:0]    o_isect_ray,
  input  logic [0:2][31:0]         i_isect_normal,
  input  logic                     i_isect_invalid,
  input  logic                     i_isect_result,
  output logic                     o_done_valid,
  input  logic                     i_done_ready,
  output logic                     o_hit,
  output logic [CNT_W-1:0]         o_hit_index,
  output logic [0:2][31:0]         o_hit_normal,
  output logic                     o_invalid_seen
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EVAL,
    S_DONE
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   base;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    idx;

  logic [CNT_W-1:0]    idx_inc;
  logic                last_tri;
  logic                take_hit;

  assign idx_inc  = idx + CNT_W'(1);
  assign last_tri = (idx_inc == count);
  // Only the first valid hit is kept, so the reported hit is always the lowest index.
  assign take_hit = i_isect_result && !i_isect_invalid && !o_hit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= S_IDLE;
      o_ray_ready    <= 1'b1;
      o_mem_rd       <= 1'b0;
      o_mem_addr     <= '0;
      o_done_valid   <= 1'b0;
      o_hit          <= 1'b0;
      o_hit_index    <= '0;
      o_hit_normal   <= '0;
      o_invalid_seen <= 1'b0;
      o_isect_tri    <= '0;
      o_isect_ray    <= '0;
      base           <= '0;
      count          <= '0;
      idx            <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_ray_valid && o_ray_ready) begin
            o_ray_ready    <= 1'b0;
            o_isect_ray    <= i_ray;
            base           <= i_base_addr;
            count          <= i_num_tris;
            idx            <= '0;
            o_hit          <= 1'b0;
            o_hit_index    <= '0;
            o_hit_normal   <= '0;
            o_invalid_seen <= 1'b0;
            if (i_num_tris == '0) begin
              state        <= S_DONE;
              o_done_valid <= 1'b1;
            end else begin
              state      <= S_FETCH;
              o_mem_rd   <= 1'b1;
              o_mem_addr <= i_base_addr;
            end
          end
        end

        // Request and address stay put until the memory accepts the read.
        S_FETCH: begin
          if (o_mem_rd && !i_mem_waitrequest) begin
            o_mem_rd <= 1'b0;
            state    <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (i_mem_rddatavalid) begin
            o_isect_tri <= i_mem_rddata;
            state       <= S_EVAL;
          end
        end

        S_EVAL: begin
          if (i_isect_invalid) begin
            o_invalid_seen <= 1'b1;
          end else if (take_hit) begin
            o_hit        <= 1'b1;
            o_hit_index  <= idx;
            o_hit_normal <= i_isect_normal;
          end
          idx <= idx_inc;
          if (last_tri || (EARLY_EXIT && take_hit)) begin
            state        <= S_DONE;
            o_done_valid <= 1'b1;
          end else begin
            state      <= S_FETCH;
            o_mem_rd   <= 1'b1;
            o_mem_addr <= base + ADDR_W'(idx_inc);
          end
        end

        S_DONE: begin
          if (o_done_valid && i_done_ready) begin
            o_done_valid <= 1'b0;
            o_ray_ready  <= 1'b1;
            state        <= S_IDLE;
          end
        end

        default: begin
          state        <= S_IDLE;
          o_ray_ready  <= 1'b1;
          o_mem_rd     <= 1'b0;
          o_done_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ray_tri_sequencer.sv
// Directed bench for ray_tri_sequencer: Avalon-style memory model with stalls/latency,
// table-driven intersection model, any-hit and full-scan instances.
module tb_ray_tri_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic                  sel;
  logic                  ray_valid;
  logic [0:1][0:2][31:0] ray;
  logic [15:0]           base_in;
  logic [15:0]           num_in;
  logic                  mem_wait;
  logic                  mem_rdv;
  logic [0:2][0:2][31:0] mem_data;
  logic [0:2][31:0]      isect_normal;
  logic                  isect_invalid;
  logic                  isect_result;
  logic                  done_ready;

  logic                  rdy   [2];
  logic                  mrd   [2];
  logic [15:0]           maddr [2];
  logic [0:2][0:2][31:0] itri  [2];
  logic [0:1][0:2][31:0] iray  [2];
  logic                  dv    [2];
  logic                  hit   [2];
  logic [15:0]           hidx  [2];
  logic [0:2][31:0]      hnorm [2];
  logic                  inv   [2];

  ray_tri_sequencer #(.ADDR_W(16), .CNT_W(16), .EARLY_EXIT(1'b1)) u_any (
    .i_clk(clk), .i_rst(rst), .i_ray_valid(ray_valid && !sel), .o_ray_ready(rdy[0]),
    .i_ray(ray), .i_base_addr(base_in), .i_num_tris(num_in),
    .o_mem_rd(mrd[0]), .o_mem_addr(maddr[0]), .i_mem_waitrequest(mem_wait),
    .i_mem_rddata(mem_data), .i_mem_rddatavalid(mem_rdv && !sel),
    .o_isect_tri(itri[0]), .o_isect_ray(iray[0]), .i_isect_normal(isect_normal),
    .i_isect_invalid(isect_invalid), .i_isect_result(isect_result),
    .o_done_valid(dv[0]), .i_done_ready(done_ready && !sel), .o_hit(hit[0]),
    .o_hit_index(hidx[0]), .o_hit_normal(hnorm[0]), .o_invalid_seen(inv[0]));

  ray_tri_sequencer #(.ADDR_W(16), .CNT_W(16), .EARLY_EXIT(1'b0)) u_full (
    .i_clk(clk), .i_rst(rst), .i_ray_valid(ray_valid && sel), .o_ray_ready(rdy[1]),
    .i_ray(ray), .i_base_addr(base_in), .i_num_tris(num_in),
    .o_mem_rd(mrd[1]), .o_mem_addr(maddr[1]), .i_mem_waitrequest(mem_wait),
    .i_mem_rddata(mem_data), .i_mem_rddatavalid(mem_rdv && sel),
    .o_isect_tri(itri[1]), .o_isect_ray(iray[1]), .i_isect_normal(isect_normal),
    .i_isect_invalid(isect_invalid), .i_isect_result(isect_result),
    .o_done_valid(dv[1]), .i_done_ready(done_ready && sel), .o_hit(hit[1]),
    .o_hit_index(hidx[1]), .o_hit_normal(hnorm[1]), .o_invalid_seen(inv[1]));

  // Selected instance's outputs
  logic                  m_rdy, m_rd, m_dv, m_hit, m_inv;
  logic [15:0]           m_addr, m_hidx;
  logic [0:2][0:2][31:0] m_tri;
  logic [0:1][0:2][31:0] m_ray;
  logic [0:2][31:0]      m_norm;
  assign m_rdy  = sel ? rdy[1]   : rdy[0];
  assign m_rd   = sel ? mrd[1]   : mrd[0];
  assign m_addr = sel ? maddr[1] : maddr[0];
  assign m_tri  = sel ? itri[1]  : itri[0];
  assign m_ray  = sel ? iray[1]  : iray[0];
  assign m_dv   = sel ? dv[1]    : dv[0];
  assign m_hit  = sel ? hit[1]   : hit[0];
  assign m_hidx = sel ? hidx[1]  : hidx[0];
  assign m_norm = sel ? hnorm[1] : hnorm[0];
  assign m_inv  = sel ? inv[1]   : inv[0];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Triangle word: fixed geometry, list index folded into the last coordinate.
  function automatic logic [0:2][0:2][31:0] make_tri(input logic [15:0] i);
    make_tri = {32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                32'h0002_0000, 32'h0003_0000, 32'h0002_0000,
                32'h0001_0000, 32'h0001_0000, 32'h0003_0000 | {16'h0, i}};
  endfunction

  // Intersection model: per-index hit/invalid tables, normal encodes the index.
  logic [15:0] hit_tab, inv_tab;
  logic [3:0]  tidx;
  assign tidx = m_tri[2][2][3:0];
  always_comb begin
    isect_result  = hit_tab[tidx];
    isect_invalid = inv_tab[tidx];
    isect_normal  = {32'h0004_0000 + {28'h0, tidx}, 32'hfffe_0000, 32'h0000_0000};
  end

  // Memory model, evaluated on the falling edge
  int          stall_cfg = 0, lat_cfg = 1;
  int          reads = 0, rd_cycles = 0, stall_left = 0, lat_left = 0;
  int          stable_err = 0, outst_err = 0;
  logic        pending = 1'b0, acc = 1'b0, req_active = 1'b0;
  logic [15:0] req_addr = '0, acc_addr = '0, job_base = '0;
  logic [15:0] addr_log [8];

  initial begin
    mem_wait = 1'b0; mem_rdv = 1'b0; mem_data = '0;
    forever begin
      @(negedge clk);
      mem_rdv = 1'b0;
      if (acc) begin
        if (pending) outst_err++;
        if (reads < 8) addr_log[reads] = acc_addr;
        reads++;
        pending    = 1'b1;
        lat_left   = lat_cfg;
        acc        = 1'b0;
        req_active = 1'b0;
      end
      if (pending) begin
        lat_left--;
        if (lat_left <= 0) begin
          mem_rdv  = 1'b1;
          mem_data = make_tri(acc_addr - job_base);
          pending  = 1'b0;
        end
      end
      if (m_rd) begin
        rd_cycles++;
        if (!req_active) begin
          req_active = 1'b1;
          stall_left = stall_cfg;
          req_addr   = m_addr;
        end else if (m_addr != req_addr) begin
          stable_err++;
        end
        if (stall_left > 0) begin
          mem_wait = 1'b1;
          stall_left--;
        end else begin
          mem_wait = 1'b0;
          acc      = 1'b1;
          acc_addr = m_addr;
        end
      end else begin
        if (req_active) stable_err++;
        mem_wait   = 1'b0;
        req_active = 1'b0;
      end
    end
  end

  logic                  r_hit, r_inv;
  logic [15:0]           r_idx;
  logic [0:2][31:0]      r_norm;
  logic [0:1][0:2][31:0] r_ray;
  int                    r_lat;

  // Issue one job, scramble i_ray mid-job, wait for done, hold ready low, handshake.
  task automatic run_job(input logic [15:0] b, input logic [15:0] n, input int hold);
    logic [0:1][0:2][31:0] ray_exp;
    logic [127:0]          snap;
    @(negedge clk);
    chk("ray_ready_before_job", m_rdy, 1'b1);
    job_base = b; reads = 0; rd_cycles = 0;
    base_in = b; num_in = n; ray_valid = 1'b1; done_ready = 1'b0;
    ray_exp = ray;
    @(posedge clk);
    r_lat = 1;
    @(negedge clk);
    ray_valid = 1'b0;
    ray = ~ray;
    while (!m_dv && r_lat < 2000) begin
      @(negedge clk);
      r_lat++;
    end
    chk("done_seen", m_dv, 1'b1);
    r_hit = m_hit; r_inv = m_inv; r_idx = m_hidx; r_norm = m_norm; r_ray = m_ray;
    chk("isect_ray_latched", r_ray, ray_exp);
    ray = ray_exp;
    snap = {m_dv, m_hit, m_inv, m_hidx, m_norm};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("done_hold_stable", {m_dv, m_hit, m_inv, m_hidx, m_norm}, snap);
    end
    done_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    done_ready = 1'b0;
    chk("ready_after_done", {m_rdy, m_dv}, 2'b10);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; ray_valid = 1'b0; done_ready = 1'b0;
    base_in = '0; num_in = '0; hit_tab = '0; inv_tab = '0;
    ray = {32'h0000_0000, 32'h0001_0000, 32'h0001_0000,
           32'h0003_0000, 32'h0000_8000, 32'h0001_8000};
    repeat (3) @(negedge clk);
    chk("reset_ready", m_rdy, 1'b1);
    chk("reset_flags", {m_rd, m_dv, m_hit, m_inv}, 4'b0000);
    chk("reset_regs", {m_addr, m_hidx, m_norm}, 128'h0);
    rst = 1'b0;

    // Empty list
    run_job(16'h0010, 16'd0, 0);
    chk("empty_latency", r_lat, 1);
    chk("empty_no_rd", rd_cycles, 0);
    chk("empty_flags", {r_hit, r_inv}, 2'b00);

    // Single triangle, zero-wait memory
    hit_tab = 16'h0001; inv_tab = 16'h0000;
    run_job(16'h0000, 16'd1, 0);
    chk("single_latency", r_lat, 4);
    chk("single_hit", r_hit, 1'b1);
    chk("single_index", r_idx, 16'd0);
    chk("single_normal", r_norm, {32'h0004_0000, 32'hfffe_0000, 32'h0000_0000});
    chk("single_tri_addr", addr_log[0], 16'h0000);

    // Early exit vs full scan, hits at idx 2 and 3
    hit_tab = 16'h000C;
    run_job(16'h0100, 16'd4, 0);
    chk("any_reads", reads, 3);
    chk("any_index", r_idx, 16'd2);
    chk("any_latency", r_lat, 10);
    sel = 1'b1;
    run_job(16'h0100, 16'd4, 0);
    chk("full_reads", reads, 4);
    chk("full_index", r_idx, 16'd2);
    chk("full_normal", r_norm, {32'h0004_0002, 32'hfffe_0000, 32'h0000_0000});
    chk("full_latency", r_lat, 13);
    sel = 1'b0;

    // Invalid at idx 1 (its result is ignored), hit at idx 3
    hit_tab = 16'h000A; inv_tab = 16'h0002;
    run_job(16'h0200, 16'd4, 0);
    chk("inv_mix", {r_hit, r_inv, r_idx}, {1'b1, 1'b1, 16'd3});
    hit_tab = 16'h000F; inv_tab = 16'h000F;
    run_job(16'h0200, 16'd4, 0);
    chk("inv_all", {r_hit, r_inv}, 2'b01);
    inv_tab = 16'h0000;

    // Stalled memory with address wrap and done-side backpressure
    hit_tab = 16'h0000; stall_cfg = 3; lat_cfg = 5; stable_err = 0; outst_err = 0;
    run_job(16'hFFFE, 16'd4, 10);
    chk("wrap_reads", reads, 4);
    chk("wrap_addrs", {addr_log[0], addr_log[1], addr_log[2], addr_log[3]},
        {16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001});
    chk("stall_stable", stable_err, 0);
    chk("one_outstanding", outst_err, 0);
    chk("stall_latency", r_lat, 41);
    chk("stall_flags", {r_hit, r_inv}, 2'b00);
    stall_cfg = 0;

    // Reset while waiting for read data; the late data must be ignored
    @(negedge clk);
    job_base = 16'h0020; reads = 0;
    base_in = 16'h0020; num_in = 16'd2; ray_valid = 1'b1;
    @(negedge clk);
    ray_valid = 1'b0;
    for (int i = 0; i < 50 && reads == 0; i++) @(negedge clk);
    chk("rst_read_issued", reads, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_idle", {m_rdy, m_dv, m_rd}, 3'b100);
    for (int i = 0; i < 20 && pending; i++) @(negedge clk);
    chk("stray_delivered", pending, 1'b0);
    repeat (2) @(negedge clk);
    chk("stray_ignored", {m_rdy, m_dv, m_rd}, 3'b100);
    lat_cfg = 1; hit_tab = 16'h0002;
    run_job(16'h0020, 16'd2, 0);
    chk("post_rst_result", {r_hit, r_idx}, {1'b1, 16'd1});
    chk("post_rst_latency", r_lat, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ray_tri_sequencer.md
Name: ray_tri_sequencer

Overview:
- Per-ray triangle sequencer that sits directly upstream of the combinational intersection unit.
- Accepts one ray (Q16.16 origin E and direction D) plus a triangle-list descriptor, then fetches triangles one at a time from triangle memory.
- Presents each triangle and the ray to the intersection unit and samples its normal/invalid/result outputs.
- Reports the lowest-index hit with its normal.

Parameters:
- ADDR_W, 16, triangle-memory word address width; one word holds one full triangle.
- CNT_W, 16, width of the triangle count.
- EARLY_EXIT, 1: 1 = stop after the first valid hit (any-hit); 0 = scan the whole list but still report the lowest-index hit.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_ray_valid  input  1  job request
- o_ray_ready  output  1  block idle and can accept a job
- i_ray  input  192  [0:1][0:2][31:0]: [0] origin, [1] direction, Q16.16 signed
- i_base_addr  input  ADDR_W  address of triangle 0
- i_num_tris  input  CNT_W  number of triangles
- o_mem_rd  output  1  read request
- o_mem_addr  output  ADDR_W  read address
- i_mem_waitrequest  input  1  read not accepted this cycle
- i_mem_rddata  input  288  triangle [0:2][0:2][31:0], [v] = vertex v
- i_mem_rddatavalid  input  1  read data valid
- o_isect_tri  output  288  triangle driven to intersection unit
- o_isect_ray  output  192  ray driven to intersection unit
- i_isect_normal  input  96  [0:2][31:0] from intersection unit
- i_isect_invalid  input  1  intersection overflow / div-by-0
- i_isect_result  input  1  intersection hit
- o_done_valid  output  1  result available
- i_done_ready  input  1  result consumed
- o_hit  output  1  at least one valid hit
- o_hit_index  output  CNT_W  index of reported hit
- o_hit_normal  output  96  normal of reported hit
- o_invalid_seen  output  1  at least one evaluated triangle returned invalid

Behaviour:
- Reset values:
  - state = IDLE, o_ray_ready = 1.
  - o_mem_rd, o_done_valid, o_hit, o_invalid_seen = 0.
  - o_hit_index, o_hit_normal, o_mem_addr, tri/ray registers = 0.
- Reset mid-operation: abandons the job next cycle. Any i_mem_rddatavalid arriving outside WAIT is ignored.
- IDLE:
  - o_ray_ready = 1.
  - On i_ray_valid & o_ray_ready: latch ray, base, count; clear idx, hit, invalid_seen.
  - If count == 0 -> DONE, else -> FETCH.
- FETCH:
  - o_mem_rd = 1, o_mem_addr = (base + idx) mod 2^ADDR_W.
  - Address and request are held stable while i_mem_waitrequest = 1.
  - When the read is accepted (o_mem_rd & !i_mem_waitrequest) -> WAIT.
  - Only one read is outstanding at any time.
- WAIT:
  - o_mem_rd = 0.
  - On i_mem_rddatavalid: latch i_mem_rddata into the tri register -> EVAL.
- EVAL (exactly 1 cycle):
  - o_isect_tri and o_isect_ray come from registers, so the intersection inputs are stable the whole cycle; isect outputs are sampled at the end of EVAL.
  - If i_isect_invalid: set invalid_seen; result and normal are ignored.
  - Else if i_isect_result & !hit: hit = 1, hit_index = idx, hit_normal = i_isect_normal. Later hits never overwrite.
  - idx increments.
  - -> DONE if (idx+1 == count) or (EARLY_EXIT & a valid hit was recorded this cycle); else -> FETCH.
- DONE:
  - o_done_valid = 1; outputs held stable until i_done_ready.
  - On o_done_valid & i_done_ready -> IDLE; o_ray_ready rises the next cycle.
- Latency:
  - Zero-wait memory returning data the cycle after acceptance: 3 cycles per triangle (FETCH, WAIT, EVAL).
  - Job accept-to-done = 1 + 3N cycles; N = 0 gives 1 cycle.
- Width rules:
  - idx is CNT_W bits; count up to 2^CNT_W − 1.
  - Address add wraps modulo 2^ADDR_W with no flag.
- o_isect_ray equals the latched ray from job accept until the next accept; i_ray changes mid-job have no effect.

Test Plan:
1. Empty list: i_num_tris = 0, i_base_addr = 0x0010 -> o_mem_rd never asserted; o_done_valid 1 cycle after accept; o_hit = 0, o_invalid_seen = 0.
2. Single triangle:
   - Stimulus: tri (1,1,1),(2,3,2),(1,1,3) = 0x00010000… words; ray E = (0,1,1), D = (3,0.5,1.5); bench model returns result = 1, normal = 00040000/fffe0000/00000000.
   - Response: o_hit = 1, o_hit_index = 0, o_hit_normal = that normal; done 4 cycles after accept with zero-wait memory.
3. Early-exit vs full scan:
   - Stimulus: 4 triangles, model hits at idx 2 and 3.
   - Response, EARLY_EXIT = 1: 3 reads issued, o_hit_index = 2.
   - Response, EARLY_EXIT = 0: 4 reads issued, o_hit_index = 2, normal from idx 2.
4. Invalid handling: invalid at idx 1, hit at idx 3 of 4 -> o_hit = 1, o_hit_index = 3, o_invalid_seen = 1. All four triangles invalid -> o_hit = 0, o_invalid_seen = 1.
5. Memory stalls and wrap:
   - Stimulus: base = 0xFFFE, 4 tris, waitrequest high 3 cycles per read, rddatavalid 5 cycles after acceptance.
   - Response: addresses FFFE, FFFF, 0000, 0001; o_mem_addr/o_mem_rd stable during stall; one outstanding read.
   - Done-side stall: o_done_valid held with outputs stable while i_done_ready = 0 for 10 cycles.
6. Reset mid-WAIT:
   - Stimulus: assert i_rst 1 cycle while in WAIT, then a stray i_mem_rddatavalid.
   - Response: ignored; o_ray_ready = 1 and o_done_valid = 0 from the first cycle after reset; a new job then completes normally.
